// File: rtl/spi_xfer_pkg.sv
// Shared types and constants for the SPI transfer sequencer.
// Register map and CSR words describe the platform SPI block's register pair.
package spi_xfer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CS_ON   = 3'd1,
        ST_WAIT_TX = 3'd2,
        ST_WR_DATA = 3'd3,
        ST_POLL    = 3'd4,
        ST_RX_OUT  = 3'd5,
        ST_CS_OFF  = 3'd6
    } state_e;

    localparam logic [1:0]  SPI_CSR_ADDR  = 2'b00;
    localparam logic [1:0]  SPI_DATA_ADDR = 2'b01;

    localparam logic [31:0] CSR_CS_ON  = 32'h0000_0081;
    localparam logic [31:0] CSR_CS_OFF = 32'h0000_0080;

    localparam int SPI_BUSY_BIT = 31;

    // States in which the sequencer owns a platform bus access.
    function automatic logic is_bus_state(input state_e s);
        return (s == ST_CS_ON) || (s == ST_WR_DATA) || (s == ST_POLL) || (s == ST_CS_OFF);
    endfunction

endpackage

// File: rtl/spi_xfer_seq_wb.sv
// Registered single-access Wishbone master: one access per accepted request,
// cyc dropped on the edge that sees ack, so at least one idle cycle follows.
module wb_single_xfer
    import spi_xfer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [1:0]  req_addr,
    input  logic        req_we,
    input  logic [31:0] req_wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic [1:0]  wb_addr,
    output logic [31:0] wb_wdata,
    output logic        wb_we,
    output logic        wb_cyc,
    input  logic [31:0] wb_rdata,
    input  logic        wb_ack
);

    logic        cyc_q,   cyc_d;
    logic        we_q,    we_d;
    logic [1:0]  addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;

    always_comb begin
        cyc_d   = cyc_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (cyc_q) begin
            if (wb_ack) begin
                cyc_d = 1'b0;
                we_d  = 1'b0;
            end
        end else if (req) begin
            // The cycle after an ack always has cyc_q low, which is the idle gap.
            cyc_d   = 1'b1;
            we_d    = req_we;
            addr_d  = req_addr;
            wdata_d = req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= SPI_CSR_ADDR;
            wdata_q <= 32'd0;
        end else begin
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign done     = cyc_q & wb_ack;
    assign rdata    = wb_rdata;
    assign wb_cyc   = cyc_q;
    assign wb_we    = we_q;
    assign wb_addr  = addr_q;
    assign wb_wdata = wdata_q;

endmodule

// File: rtl/spi_xfer_seq.sv
// Byte-stream SPI sequencer: turns cmd/tx/rx streams into CSR and data register
// accesses on the platform SPI block, polling its busy bit per byte.
//
// state      | meaning
// IDLE       | waiting for a command, cmd_ready high
// CS_ON      | writing CSR: enable + chip select asserted
// WAIT_TX    | waiting for the next TX byte, tx_ready high
// WR_DATA    | writing the TX byte to the data register
// POLL       | reading the data register until busy clears
// RX_OUT     | presenting the captured byte on the RX stream
// CS_OFF     | writing CSR: enable kept, chip select released
module spi_xfer_seq
    import spi_xfer_pkg::*;
#(
    parameter int LEN_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_keep_cs,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             busy,
    output logic [1:0]       wb_addr,
    output logic [31:0]      wb_wdata,
    output logic             wb_we,
    output logic             wb_cyc,
    input  logic [31:0]      wb_rdata,
    input  logic             wb_ack
);

    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    state_e           state_q,    state_d;
    logic [LEN_W-1:0] count_q,    count_d;
    logic             keep_q,     keep_d;
    logic [7:0]       byte_q,     byte_d;
    logic [7:0]       rx_data_q,  rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic [LEN_W-1:0] count_dec;

    logic        xfer_req;
    logic [1:0]  xfer_addr;
    logic        xfer_we;
    logic [31:0] xfer_wdata;
    logic        xfer_done;
    logic [31:0] xfer_rdata;
    logic        unused_rdata_bits;

    assign unused_rdata_bits = ^xfer_rdata[30:8];

    // Zero is tested before subtracting, so the count can never wrap.
    assign count_dec = (count_q != '0) ? (count_q - LEN_ONE) : '0;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        keep_d     = keep_q;
        byte_d     = byte_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        xfer_req   = is_bus_state(state_q);
        xfer_addr  = SPI_CSR_ADDR;
        xfer_we    = 1'b0;
        xfer_wdata = 32'd0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    count_d = cmd_len;
                    keep_d  = cmd_keep_cs;
                    state_d = ST_CS_ON;
                end
            end
            ST_CS_ON: begin
                xfer_we    = 1'b1;
                xfer_wdata = CSR_CS_ON;
                if (xfer_done) begin
                    if (count_q != '0) begin
                        state_d = ST_WAIT_TX;
                    end else begin
                        state_d = keep_q ? ST_IDLE : ST_CS_OFF;
                    end
                end
            end
            ST_WAIT_TX: begin
                if (tx_valid) begin
                    byte_d  = tx_data;
                    state_d = ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                xfer_addr  = SPI_DATA_ADDR;
                xfer_we    = 1'b1;
                xfer_wdata = {24'd0, byte_q};
                if (xfer_done) begin
                    state_d = ST_POLL;
                end
            end
            ST_POLL: begin
                // A busy read simply stays here; the held request re-issues it.
                xfer_addr = SPI_DATA_ADDR;
                if (xfer_done && !xfer_rdata[SPI_BUSY_BIT]) begin
                    rx_data_d  = xfer_rdata[7:0];
                    rx_valid_d = 1'b1;
                    state_d    = ST_RX_OUT;
                end
            end
            ST_RX_OUT: begin
                if (rx_ready) begin
                    rx_valid_d = 1'b0;
                    count_d    = count_dec;
                    if (count_dec != '0) begin
                        state_d = ST_WAIT_TX;
                    end else begin
                        state_d = keep_q ? ST_IDLE : ST_CS_OFF;
                    end
                end
            end
            ST_CS_OFF: begin
                xfer_we    = 1'b1;
                xfer_wdata = CSR_CS_OFF;
                if (xfer_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                rx_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            keep_q     <= 1'b0;
            byte_q     <= 8'd0;
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            keep_q     <= keep_d;
            byte_q     <= byte_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    wb_single_xfer u_wb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (xfer_req),
        .req_addr  (xfer_addr),
        .req_we    (xfer_we),
        .req_wdata (xfer_wdata),
        .done      (xfer_done),
        .rdata     (xfer_rdata),
        .wb_addr   (wb_addr),
        .wb_wdata  (wb_wdata),
        .wb_we     (wb_we),
        .wb_cyc    (wb_cyc),
        .wb_rdata  (wb_rdata),
        .wb_ack    (wb_ack)
    );

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign tx_ready  = (state_q == ST_WAIT_TX);
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;

endmodule

// File: doc/spi_xfer_seq.md
# spi_xfer_seq

Byte-stream SPI transfer sequencer: a Wishbone master that drives the platform SPI register pair (CSR at word 0, data at word 1) so that the rest of the SoC can move SPI bytes with valid/ready streams instead of CPU polling. It sits directly upstream of the platform block's bus port. It takes a command of N bytes, asserts chip select, pushes each TX byte into the data register and polls busy. It returns each captured MISO byte on an RX stream, then optionally releases chip select.

## Interface
- LEN_W, 12: width of byte count; max transfer 2^LEN_W-1 bytes.
- clk  in  1  system clock, single domain.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_len  in  LEN_W  bytes to transfer; 0 allowed.
- cmd_keep_cs  in  1  1: leave CS asserted at end of command.
- cmd_valid / cmd_ready  in / out  1  command handshake; cmd_ready high only in IDLE.
- tx_data  in  8  byte to shift out.
- tx_valid / tx_ready  in / out  1  TX stream handshake.
- rx_data  out  8  byte captured from MISO.
- rx_valid / rx_ready  out / in  1  RX stream handshake.
- busy  out  1  high whenever FSM not in IDLE.
- wb_addr  out  2  platform register word address.
- wb_wdata  out  32  write data.
- wb_we  out  1  write enable.
- wb_cyc  out  1  cycle/strobe.
- wb_rdata  in  32  read data, valid when wb_ack is high.
- wb_ack  in  1  single-cycle ack from platform.

## Operation
- States: IDLE, CS_ON, WAIT_TX, WR_DATA, POLL, RX_OUT, CS_OFF.
- IDLE: cmd_ready=1. On cmd_valid, latch cmd_len into remaining count and latch cmd_keep_cs, then go to CS_ON.
- CS_ON: write 0x0000_0081 to addr 0 (enable=1, CS asserted). After ack: remaining==0 goes to CS_OFF, or to IDLE if keep_cs. Otherwise go to WAIT_TX.
- WAIT_TX: tx_ready=1. On tx_valid, latch the byte and go to WR_DATA. tx_ready is low in every other state.
- WR_DATA: write {24'd0, byte} to addr 1. After ack, go to POLL.
- POLL: read addr 1. On ack, wb_rdata[31]=1 means re-issue the read. wb_rdata[31]=0 means latch wb_rdata[7:0] into rx_data and go to RX_OUT.
- RX_OUT: rx_valid=1 and rx_data is held stable until rx_ready. The count decrements on handshake. remaining≠0 goes to WAIT_TX; otherwise keep_cs goes to IDLE, else CS_OFF.
- CS_OFF: write 0x0000_0080 to addr 0 (enable kept, CS released). After ack, go to IDLE.
- Count arithmetic is LEN_W-bit unsigned. The decrement happens only in RX_OUT and never wraps, because 0 is tested first.
- Stream stalls (tx_valid low, rx_ready low) are unbounded. No bus access is issued while stalled.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE and wb_cyc=wb_we=0. wb_addr=0, wb_wdata=0, rx_data=0 and count=0. rx_valid=tx_ready=busy=0 and cmd_ready=1.
- All outputs are registered except cmd_ready, tx_ready and busy, which are decoded from state.
- Bus access sequence:
  - wb_cyc rises in cycle N with addr, we and wdata stable.
  - The platform acks in N+1.
  - wb_cyc is low in N+2, giving at least one idle cycle between accesses.
  - wb_cyc must drop on the edge where ack is seen, so there is never a second ack.
- First POLL read starts at least 2 cycles after WR_DATA ack. This guarantees the platform busy bit is already set.
- Minimum per byte with zero stalls: WR access 3 cycles, about 12 cycles of polling (10 shift cycles plus read latency), RX handshake 1 cycle.
- rx_valid asserts the cycle after the final poll ack.
- Reset mid-access drops wb_cyc immediately. The platform CS state is left as last written; the platform has its own reset.
- A cmd_valid arriving while busy is ignored (not latched).

## Structure
- Package spi_xfer_pkg holds the following:
  - State enum.
  - SPI_CSR_ADDR=2'b00 and SPI_DATA_ADDR=2'b01.
  - CSR_CS_ON=32'h81 and CSR_CS_OFF=32'h80.
  - SPI_BUSY_BIT=31.
- One sub-module, wb_single_xfer: a registered single-access Wishbone master. It takes a req/addr/we/wdata pulse and returns a done/rdata pulse, and it enforces the cyc-drop-on-ack and idle-gap rules. The FSM in spi_xfer_seq sequences it.

## Test plan
Benches use a behavioural platform model: registered ack, busy for 10 cycles, MISO = bit-inverted TX.
- Reset with rst_n=0 mid-WR_DATA -> wb_cyc=0 at once; after release: cmd_ready=1, busy=0, rx_valid=0.
- cmd_len=1, keep_cs=0, tx 0xA5 -> bus writes addr0=0x81, addr1=0xA5, then polls until bit31=0. rx_data=0x5A is presented, then addr0=0x80 is written and busy falls.
- cmd_len=3, keep_cs=1, tx 0x01,0x02,0x03 with rx_ready held low 20 cycles on byte 2 -> rx 0xFE,0xFD,0xFC in order. No bus traffic during the stall; no final CSR write.
- cmd_len=0, keep_cs=0 -> exactly two writes (0x81 then 0x80); no tx_ready, no rx_valid.
- tx_valid withheld 50 cycles after CS_ON -> tx_ready=1 throughout; wb_cyc stays 0 until the byte arrives.
- cmd_valid pulsed while busy -> ignored; only the first command's bytes are transferred and the count equals the first cmd_len.
